// File: rtl/flash_loader.sv
// -----------------------------------------------------------------------------
// flash_loader
//
// Boot-time copy engine. Walks WORD_COUNT words of flash starting at
// FLASH_BASE, fetching each one through the flash reader's address /
// read_ctrl toggle handshake, and writes it into main RAM starting at
// RAM_BASE. Raises done when the copy completes, which releases the CPU
// from reset hold. Raises error if the reader stalls longer than TIMEOUT
// cycles in either wait state.
//
// Optional feature (compile-time macro):
//   FLASH_LOADER_CHECKSUM_EN  when defined, checksum is the modulo-2^16 sum
//                             of every word written during the current copy.
//                             When undefined, checksum is tied to zero and
//                             no adder is built.
//
// Ports:
//   clk            system clock, shared with the flash reader
//   rst            synchronous, active-low reset
//   start          level input; a rising edge seen in IDLE/DONE/ERROR starts
//                  a new copy, edges while busy are ignored
//   flash_addr_req flash word address to the reader (held for the whole
//                  reader transaction)
//   read_ctrl      toggled once per word to launch a reader transaction
//   flash_status   reader status; low nibble 4'b0001 means reader idle
//   flash_word     reader data word
//   ram_addr       RAM word address
//   ram_wdata      RAM write data
//   ram_we         RAM write strobe, high for WR_HOLD cycles per word
//   busy           high while a copy is in progress
//   done           high once a copy has completed
//   error          high once a reader timeout has aborted a copy
//   checksum       running sum of written words (see macro above)
// -----------------------------------------------------------------------------
module flash_loader #(
  parameter logic [22:0] FLASH_BASE = 23'h000000,
  parameter logic [17:0] RAM_BASE   = 18'h00000,
  parameter logic [15:0] WORD_COUNT = 16'd1024,
  parameter logic [3:0]  WR_HOLD    = 4'd2,
  parameter logic [31:0] TIMEOUT    = 32'd200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [22:0] flash_addr_req,
  output logic        read_ctrl,
  input  logic [7:0]  flash_status,
  input  logic [15:0] flash_word,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam logic [3:0] RDR_IDLE  = 4'b0001;
  localparam logic [7:0] RDR_FAULT = 8'hff;

  logic [2:0]  state;
  logic        start_p0;
  logic        start_p1;
  logic [15:0] idx;
  logic [15:0] idx_nxt;
  logic [31:0] wait_cnt;
  logic [3:0]  hold_cnt;
  logic        start_rise;
  logic        accept;
  logic        rdr_idle;
  logic        timed_out;
  logic        hold_done;

  // Address generation: base plus word index, truncated to the port width
  // so both address spaces wrap rather than saturate.
  function automatic logic [22:0] flash_addr_of(input logic [15:0] i);
    return FLASH_BASE + {7'd0, i};
  endfunction

  function automatic logic [17:0] ram_addr_of(input logic [15:0] i);
    return RAM_BASE + {2'd0, i};
  endfunction

  assign busy  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

  assign start_rise = start_p0 & ~start_p1;
  assign accept     = start_rise & ~busy;
  assign idx_nxt    = idx + 16'd1;

  // The fault status 8'hff already fails the nibble compare; it is spelled out
  // so a stuck reader is visibly excluded from ever reading as idle.
  assign rdr_idle  = (flash_status[3:0] == RDR_IDLE) && (flash_status != RDR_FAULT);

  // Wide compares so TIMEOUT=0 and WR_HOLD=0 degrade to "one cycle" safely.
  assign timed_out = ({1'b0, wait_cnt} + 33'd1) >= {1'b0, TIMEOUT};
  assign hold_done = ({1'b0, hold_cnt} + 5'd1) >= {1'b0, WR_HOLD};

  // Stage p0/p1: start synchroniser and edge detect; FSM and datapath below.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      start_p0       <= 1'b0;
      start_p1       <= 1'b0;
      idx            <= 16'd0;
      read_ctrl      <= 1'b0;
      flash_addr_req <= FLASH_BASE;
      ram_addr       <= RAM_BASE;
      ram_wdata      <= 16'd0;
      ram_we         <= 1'b0;
      wait_cnt       <= 32'd0;
      hold_cnt       <= 4'd0;
    end else begin
      start_p0 <= start;
      start_p1 <= start_p0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept) begin
            if (WORD_COUNT == 16'd0) begin
              state <= S_DONE;
            end else begin
              idx   <= 16'd0;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Address and toggle change on the same edge; the reader sees a
          // stable address for the whole transaction it launches.
          flash_addr_req <= flash_addr_of(idx);
          read_ctrl      <= ~read_ctrl;
          wait_cnt       <= 32'd0;
          state          <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!rdr_idle) begin
            wait_cnt <= 32'd0;
            state    <= S_WAIT_IDLE;
          end else if (timed_out) begin
            state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (rdr_idle) begin
            ram_wdata <= flash_word;
            ram_addr  <= ram_addr_of(idx);
            ram_we    <= 1'b1;
            hold_cnt  <= 4'd0;
            state     <= S_WRITE;
          end else if (timed_out) begin
            state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WRITE: begin
          // ram_we is dropped on the same edge that leaves WRITE, so the
          // strobe covers exactly the WRITE cycles of one address.
          if (hold_done) begin
            ram_we <= 1'b0;
            state  <= S_NEXT;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_NEXT: begin
          idx <= idx_nxt;
          if (idx_nxt == WORD_COUNT) begin
            state <= S_DONE;
          end else begin
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [15:0] sum_p0;

  // Accumulate once per word, in the first WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_p0 <= 16'd0;
    end else if (accept && (WORD_COUNT != 16'd0)) begin
      sum_p0 <= 16'd0;
    end else if ((state == S_WRITE) && (hold_cnt == 4'd0)) begin
      sum_p0 <= sum_p0 + ram_wdata;
    end
  end

  assign checksum = sum_p0;
`else
  assign checksum = 16'h0000;
`endif

endmodule
